// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE 754 single-precision field widths, exponent
// constants and the state encoding used by the sequential FPU blocks.
package fpu_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_INT_W  = 32;

  localparam logic [FP_EXP_W-1:0] FP_BIAS        = 8'd127;
  // Exponent of 2^31: the largest magnitude a 32-bit integer can carry.
  localparam logic [FP_EXP_W-1:0] FP_EXP_INT_MAX = FP_BIAS + 8'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  // Two's-complement magnitude; -2^31 wraps to 0x80000000, which is the
  // correct unsigned magnitude.
  function automatic logic [FP_INT_W-1:0] int_mag(input logic [FP_INT_W-1:0] v);
    int_mag = v[FP_INT_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational fraction rounding for the integer-to-float packer.
// FP_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise truncation.
module fp_round
  import fpu_pkg::*;
(
  input  logic [FP_FRAC_W-1:0] frac_i,
  input  logic                 guard_i,
  input  logic                 sticky_i,
  input  logic [FP_EXP_W-1:0]  exp_i,
  output logic [FP_FRAC_W-1:0] frac_o,
  output logic [FP_EXP_W-1:0]  exp_o
);

`ifdef FP_ROUND_NEAREST_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  logic               round_up;
  logic [FP_FRAC_W:0] frac_sum;

  assign round_up = ROUND_EN & guard_i & (sticky_i | frac_i[0]);
  assign frac_sum = {1'b0, frac_i} + {{FP_FRAC_W{1'b0}}, round_up};

  // On carry-out the low bits are already zero, so only the exponent moves.
  assign frac_o = frac_sum[FP_FRAC_W-1:0];
  assign exp_o  = exp_i + {{(FP_EXP_W-1){1'b0}}, frac_sum[FP_FRAC_W]};

endmodule

// File: rtl/int_to_fp_encoder.sv
// 32-bit signed integer to IEEE 754 single encoder, normalizing one bit per
// cycle. Rounding mode is chosen by FP_ROUND_NEAREST_EN inside fp_round.
module int_to_fp_encoder
  import fpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_INT_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_INT_W-1:0] out_data
);

  enc_state_e            state_q, state_d;
  logic [FP_INT_W-1:0]   mag_q, mag_d;
  logic [FP_EXP_W-1:0]   exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic [FP_INT_W-1:0]   out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic [FP_INT_W-1:0]   in_mag;
  logic [FP_FRAC_W-1:0]  rnd_frac;
  logic [FP_EXP_W-1:0]   rnd_exp;

  assign in_mag = int_mag(in_data);

  // mag_q[31] is the hidden bit once normalized; the next bit below the
  // fraction is the guard and the rest fold into sticky.
  fp_round u_round (
    .frac_i   (mag_q[30:8]),
    .guard_i  (mag_q[7]),
    .sticky_i (|mag_q[6:0]),
    .exp_i    (exp_q),
    .frac_o   (rnd_frac),
    .exp_o    (rnd_exp)
  );

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_data[FP_INT_W-1];
          mag_d  = in_mag;
          if (in_mag == '0) begin
            out_data_d  = '0;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            exp_d   = FP_EXP_INT_MAX;
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (!mag_q[FP_INT_W-1]) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end else begin
          out_data_d  = {sign_q, rnd_exp, rnd_frac};
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_int_to_fp_encoder.sv
// Randomized and directed bench for int_to_fp_encoder against an arithmetic
// reference model; honours FP_ROUND_NEAREST_EN the same way as the design.
module tb_int_to_fp_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int total = 0;
  int bad   = 0;

  int_to_fp_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Position of the most significant set bit of a nonzero magnitude.
  function automatic int msb_pos(input longint m);
    int e = 0;
    while ((m >> (e + 1)) != 0) e++;
    return e;
  endfunction

  function automatic logic [31:0] ref_fp(input logic [31:0] x);
    longint v, m, q, rem, half;
    int e, sh;
    logic s;
    v = longint'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 32'h0;
    e = msb_pos(m);
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
`ifdef FP_ROUND_NEAREST_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
      if (rem < 0) q = q;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {s, 8'(127 + e), 23'(q - (longint'(1) << 23))};
  endfunction

  function automatic int ref_lat(input logic [31:0] x);
    longint v, m;
    v = longint'($signed(x));
    m = (v < 0) ? -v : v;
    return (m == 0) ? 0 : (31 - msb_pos(m)) + 1;
  endfunction

  // Waits for in_ready, presents x for exactly the accept edge, returns #1 after it.
  task automatic send(input logic [31:0] x);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  // Called #1 after the accept edge; checks latency, data, and handshake release.
  task automatic recv(input string tag, input logic [31:0] exp_data, input int exp_lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check_val({tag, "_data"}, out_data, exp_data);
    $display("xfer %s data=%08h lat=%0d", tag, out_data, n);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({tag, "_ovalid_clr"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_iready_set"}, {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y_rne;
    logic [31:0] y_trunc;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] x, held, y_exp;

    vecs[0] = '{32'h00000001, 32'h3F800000, 32'h3F800000, 32};
    vecs[1] = '{32'hFFFFFFFF, 32'hBF800000, 32'hBF800000, 32};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'h00000000, 0};
    vecs[3] = '{32'h80000000, 32'hCF000000, 32'hCF000000, 1};
    vecs[4] = '{32'h7FFFFFFF, 32'h4F000000, 32'h4EFFFFFF, 2};
    vecs[5] = '{32'h01000003, 32'h4B800002, 32'h4B800001, 8};
    vecs[6] = '{32'h01000001, 32'h4B800000, 32'h4B800000, 8};

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ovalid", {31'd0, out_valid}, 32'd0);
    check_val("rst_odata", out_data, 32'd0);
    check_val("rst_iready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_iready", {31'd0, in_ready}, 32'd1);
    check_val("post_rst_ovalid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 7; i++) begin
`ifdef FP_ROUND_NEAREST_EN
      y_exp = vecs[i].y_rne;
`else
      y_exp = vecs[i].y_trunc;
`endif
      check_val("model_vs_table", ref_fp(vecs[i].x), y_exp);
      send(vecs[i].x);
      recv($sformatf("dir%0d", i), y_exp, vecs[i].lat);
    end

    // Output back-pressure: result held, new operand refused until release.
    send(32'd1000);
    while (!out_valid) begin
      @(posedge clk); #1;
    end
    held     = out_data;
    check_val("bp_data", held, ref_fp(32'd1000));
    in_valid = 1'b1;
    in_data  = 32'hFFFFF000;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_val("bp_hold_data", out_data, held);
      check_val("bp_hold_iready", {31'd0, in_ready}, 32'd0);
      check_val("bp_hold_ovalid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("bp_rel_ovalid", {31'd0, out_valid}, 32'd0);
    check_val("bp_rel_iready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'h12345678;
    check_val("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    recv("bp_next", ref_fp(32'hFFFFF000), ref_lat(32'hFFFFF000));

    // Asynchronous abort in the middle of normalization.
    send(32'h00000003);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("abort_ovalid", {31'd0, out_valid}, 32'd0);
    check_val("abort_iready", {31'd0, in_ready}, 32'd1);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("abort_no_stale", {31'd0, out_valid}, 32'd0);
    send(32'hFFFF8001);
    recv("after_abort", ref_fp(32'hFFFF8001), ref_lat(32'hFFFF8001));

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: x = $urandom;
        1: x = $urandom >> $urandom_range(0, 31);
        2: x = -($urandom >> $urandom_range(0, 31));
        default: x = ($urandom | 32'h00FFFFFF) >> $urandom_range(0, 8);
      endcase
      send(x);
      recv($sformatf("rnd%0d_%08h", i, x), ref_fp(x), ref_lat(x));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
